// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
// The derived widths here describe the default configuration; the modules re-derive them from their own parameters.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } state_t;

  function automatic int off_bits(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 0;
  endfunction

  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  localparam int OFF_W = off_bits(2);
  localparam int IDX_W = idx_bits(16);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  // Clears the byte and word-offset bits so the result points at the start of a line.
  function automatic logic [63:0] line_addr(input logic [63:0] pc, input int off_w);
    return pc & (~64'd0 << (2 + off_w));
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill sequencer: latches the missing line address, runs the req/ack handshake
// and aborts with a sticky error when memory does not answer in time.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              mem_ack,
  output state_t            state,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              fill_we,
  output logic              refill_err
);

  localparam int TW = $clog2(TIMEOUT);

  state_t        next;
  logic [TW-1:0] wait_cnt;
  logic          timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (miss) next = REQ;
      REQ:  next = WAIT;
      WAIT: begin
        if (mem_ack)      next = FILL;
        else if (timeout) next = IDLE;
      end
      FILL: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // An ack on the final allowed cycle still wins over the timeout.
  always_comb begin
    mem_req = (state == REQ) || (state == WAIT);
    fill_we = (state == WAIT) && mem_ack;
    timeout = (state == WAIT) && !mem_ack && (wait_cnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      mem_addr   <= '0;
      refill_err <= 1'b0;
    end else begin
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
      if (state == IDLE && miss) mem_addr <= miss_addr;
      if (timeout) refill_err <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_dm_ctrl.sv
// Direct-mapped instruction cache for the fetch stage: same-cycle hit path,
// line refill through icache_refill_fsm, whole-cache flush and saturating counters.
module icache_dm_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 2,
  parameter int NUM_LINES  = 16,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            pc_f,
  input  logic                         fetch_en,
  input  logic                         flush,
  output logic [DATA_W-1:0]            instr_f,
  output logic                         stall_f,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_line,
  output logic                         refill_err,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt
);

  localparam int OFF_BITS = off_bits(LINE_WORDS);
  localparam int IDX_BITS = idx_bits(NUM_LINES);
  localparam int TAG_BITS = ADDR_W - 2 - OFF_BITS - IDX_BITS;
  localparam int OFF_IW   = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int LINE_W   = LINE_WORDS * DATA_W;

  logic [TAG_BITS-1:0] tag_arr  [NUM_LINES];
  logic [LINE_W-1:0]   data_arr [NUM_LINES];
  logic [NUM_LINES-1:0] valid;

  logic [IDX_BITS-1:0] idx, fill_idx;
  logic [TAG_BITS-1:0] tag, fill_tag;
  logic [OFF_IW-1:0]   off;
  logic [LINE_W-1:0]   line_sel;
  logic [DATA_W-1:0]   word;
  logic [ADDR_W-1:0]   miss_addr;
  state_t              state;
  logic                hit, miss, fill_we, flush_pend;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign idx       = IDX_BITS'(pc_f >> (2 + OFF_BITS));
  assign tag       = TAG_BITS'(pc_f >> (2 + OFF_BITS + IDX_BITS));
  assign off       = (LINE_WORDS > 1) ? OFF_IW'(pc_f >> 2) : '0;
  assign fill_idx  = IDX_BITS'(mem_addr >> (2 + OFF_BITS));
  assign fill_tag  = TAG_BITS'(mem_addr >> (2 + OFF_BITS + IDX_BITS));
  assign miss_addr = ADDR_W'(line_addr(64'(pc_f), OFF_BITS));

  assign line_sel = data_arr[idx];
  assign word     = line_sel[off*DATA_W +: DATA_W];

  assign hit     = fetch_en & valid[idx] & (tag_arr[idx] == tag) & (state == IDLE);
  assign miss    = fetch_en & ~hit & (state == IDLE);
  assign stall_f = (state != IDLE) | miss;
  assign instr_f = hit ? word : '0;

  icache_refill_fsm #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_refill (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss       (miss),
    .miss_addr  (miss_addr),
    .mem_ack    (mem_ack),
    .state      (state),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .fill_we    (fill_we),
    .refill_err (refill_err)
  );

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr[fill_idx] <= mem_line;
      tag_arr[fill_idx]  <= fill_tag;
    end
  end

  // A flush seen while a refill is in flight must also kill the line that refill brings in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (state == IDLE)  flush_pend <= 1'b0;
      else if (flush)     flush_pend <= 1'b1;
      if (flush)   valid <= '0;
      if (fill_we) valid[fill_idx] <= ~(flush | flush_pend);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= sat_inc(hit_cnt);
      if (miss) miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_icache_dm_ctrl.sv
// Directed bench for icache_dm_ctrl with LINE_WORDS=2, NUM_LINES=16, TIMEOUT=8, CNT_W=4.
module tb_icache_dm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        fetch_en;
  logic        flush;
  logic [31:0] instr_f;
  logic        stall_f;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_line;
  logic        refill_err;
  logic [3:0]  hit_cnt;
  logic [3:0]  miss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  icache_dm_ctrl #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .LINE_WORDS (2),
    .NUM_LINES  (16),
    .TIMEOUT    (8),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_f       (pc_f),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .instr_f    (instr_f),
    .stall_f    (stall_f),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_line   (mem_line),
    .refill_err (refill_err),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic miss_start(input logic [31:0] pc);
    @(negedge clk);
    pc_f = pc; fetch_en = 1'b1; flush = 1'b0; mem_ack = 1'b0;
    #1;
    check("miss_stall", stall_f, 1);
    check("miss_instr", instr_f, 0);
  endtask

  // Starts in the REQ cycle; acks in WAIT cycle k, optionally pulses flush in WAIT cycle flush_at.
  task automatic refill_tail(input logic [31:0] addr, input logic [63:0] line, input int k,
                             input int flush_at, input int exp_miss);
    @(negedge clk);
    #1;
    check("req_mem_req", mem_req, 1);
    check("req_mem_addr", mem_addr, addr);
    check("req_stall", stall_f, 1);
    check("req_miss_cnt", miss_cnt, exp_miss);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      mem_ack = (i == k); flush = (i == flush_at); mem_line = line;
      #1;
      check("wait_mem_req", mem_req, 1);
      check("wait_stall", stall_f, 1);
    end
    @(negedge clk);
    mem_ack = 1'b0; flush = 1'b0;
    #1;
    check("fill_stall", stall_f, 1);
    check("fill_mem_req", mem_req, 0);
  endtask

  task automatic hit_fetch(input logic [31:0] pc, input logic [31:0] exp);
    @(negedge clk);
    pc_f = pc; fetch_en = 1'b1; flush = 1'b0; mem_ack = 1'b0;
    #1;
    check("hit_stall", stall_f, 0);
    check("hit_instr", instr_f, exp);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    fetch_en = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc_f = '0; fetch_en = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_line = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_stall", stall_f, 0);
    check("rst_err", refill_err, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_instr", instr_f, 0);
    rst_n = 1'b1;

    // Basic miss, refill with ack in the third WAIT cycle, then two hits in the line
    miss_start(32'h40);
    refill_tail(32'h40, {32'hB, 32'hA}, 3, 0, 1);
    hit_fetch(32'h40, 32'hA);
    hit_fetch(32'h44, 32'hB);
    idle_cycle();
    check("t1_hit_cnt", hit_cnt, 2);

    // Conflict on index 8
    miss_start(32'h440);
    refill_tail(32'h440, {32'hD, 32'hC}, 1, 0, 2);
    hit_fetch(32'h440, 32'hC);
    miss_start(32'h40);
    refill_tail(32'h40, {32'hB, 32'hA}, 2, 0, 3);
    hit_fetch(32'h40, 32'hA);

    // Timeout after 8 WAIT cycles, then retry
    miss_start(32'h80);
    @(negedge clk);
    #1;
    check("to_req", mem_req, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      check("to_wait_req", mem_req, 1);
    end
    check("to_err_before", refill_err, 0);
    @(negedge clk);
    #1;
    check("to_req_drop", mem_req, 0);
    check("to_err", refill_err, 1);
    check("to_remiss_stall", stall_f, 1);
    refill_tail(32'h80, {32'h22, 32'h11}, 1, 0, 5);
    hit_fetch(32'h80, 32'h11);
    idle_cycle();
    check("to_err_sticky", refill_err, 1);

    // Flush in IDLE: the same-cycle hit is served, both lines then miss
    @(negedge clk);
    pc_f = 32'h80; fetch_en = 1'b1; flush = 1'b1;
    #1;
    check("flush_hit_stall", stall_f, 0);
    check("flush_hit_instr", instr_f, 32'h11);
    miss_start(32'h80);
    refill_tail(32'h80, {32'h22, 32'h11}, 1, 0, 6);
    hit_fetch(32'h84, 32'h22);
    miss_start(32'h40);
    refill_tail(32'h40, {32'hB, 32'hA}, 2, 1, 7);
    // Flush during WAIT: the filled line stays invalid and index 0 was cleared too
    miss_start(32'h40);
    refill_tail(32'h40, {32'hB, 32'hA}, 1, 0, 8);
    hit_fetch(32'h40, 32'hA);
    miss_start(32'h80);
    refill_tail(32'h80, {32'h22, 32'h11}, 1, 0, 9);
    hit_fetch(32'h80, 32'h11);

    // Saturation: hit count is 9 here, twenty more hits pin it at 15
    for (int i = 0; i < 20; i++)
      hit_fetch((i % 2) ? 32'h84 : 32'h80, (i % 2) ? 32'h22 : 32'h11);
    idle_cycle();
    check("sat_hit_cnt", hit_cnt, 15);
    check("sat_miss_cnt", miss_cnt, 9);

    // Asynchronous reset in the middle of WAIT
    miss_start(32'h100);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    fetch_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_stall", stall_f, 0);
    check("arst_hit_cnt", hit_cnt, 0);
    check("arst_miss_cnt", miss_cnt, 0);
    check("arst_err", refill_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_line = {32'h77, 32'h66};
    #1;
    check("late_ack_req", mem_req, 0);
    check("late_ack_stall", stall_f, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack_after", stall_f, 0);
    miss_start(32'h80);
    idle_cycle();
    check("arst_remiss_cnt", miss_cnt, 1);
    check("arst_remiss_req", mem_req, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
